// File: rtl/axil_sram_frontend.sv
// AXI4-Lite slave front-end for a two-port word SRAM (port A read, port B write).
// Optional address window check enabled by defining AXIL_SRAM_RANGE_CHECK_EN.
module axil_sram_frontend #(
   parameter int                    ADDR_W     = 10,
   parameter int                    DATA_W     = 32,
   parameter int                    BYTE_W     = DATA_W/8,
   parameter int                    AXI_ADDR_W = 32,
   parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AXI_ADDR_W-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [BYTE_W-1:0]     s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [AXI_ADDR_W-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  sram_a_en,
   output logic                  sram_a_re,
   output logic [ADDR_W-1:0]     sram_a_addr,
   input  logic [DATA_W-1:0]     sram_a_rdata,
   input  logic                  sram_a_rvalid,
   output logic                  sram_b_en,
   output logic                  sram_b_we,
   output logic [ADDR_W-1:0]     sram_b_addr,
   output logic [DATA_W-1:0]     sram_b_wdata,
   output logic [BYTE_W-1:0]     sram_b_wmask
);

   localparam logic [1:0] W_COLLECT   = 2'd0;
   localparam logic [1:0] W_ISSUE     = 2'd1;
   localparam logic [1:0] W_RESP      = 2'd2;
   localparam logic [1:0] R_IDLE      = 2'd0;
   localparam logic [1:0] R_WAIT      = 2'd1;
   localparam logic [1:0] R_RESP      = 2'd2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]        w_state_reg, w_state_next;
   logic [1:0]        r_state_reg, r_state_next;
   logic              aw_full_reg, w_full_reg, aw_err_reg;
   logic [ADDR_W-1:0] aw_addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [BYTE_W-1:0] wmask_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic [1:0]        rresp_reg;
   logic              aw_hs, w_hs, ar_hs;
   logic              aw_oor, ar_oor;
   logic              unused_addr_bits;

`ifdef AXIL_SRAM_RANGE_CHECK_EN
   // One extra bit so the window end cannot wrap at the top of the address space.
   localparam logic [AXI_ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [AXI_ADDR_W:0] WIN_HI = WIN_LO + ((AXI_ADDR_W+1)'(1) << (ADDR_W+2));

   assign aw_oor = ({1'b0, s_awaddr} < WIN_LO) || ({1'b0, s_awaddr} >= WIN_HI);
   assign ar_oor = ({1'b0, s_araddr} < WIN_LO) || ({1'b0, s_araddr} >= WIN_HI);
   assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
   assign aw_oor = 1'b0;
   assign ar_oor = 1'b0;
   assign unused_addr_bits = ^{s_awaddr[AXI_ADDR_W-1:ADDR_W+2], s_awaddr[1:0],
                               s_araddr[AXI_ADDR_W-1:ADDR_W+2], s_araddr[1:0]};
`endif

   // Write channel
   assign s_awready = (w_state_reg == W_COLLECT) && !aw_full_reg;
   assign s_wready  = (w_state_reg == W_COLLECT) && !w_full_reg;
   assign aw_hs     = s_awvalid && s_awready;
   assign w_hs      = s_wvalid && s_wready;

   always_comb begin
      w_state_next = w_state_reg;
      case (w_state_reg)
         W_COLLECT: if ((aw_full_reg || aw_hs) && (w_full_reg || w_hs)) w_state_next = W_ISSUE;
         W_ISSUE:   w_state_next = W_RESP;
         W_RESP:    if (s_bready) w_state_next = W_COLLECT;
         default:   w_state_next = W_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_reg <= W_COLLECT;
         aw_full_reg <= 1'b0;
         w_full_reg  <= 1'b0;
         aw_err_reg  <= 1'b0;
         aw_addr_reg <= '0;
         wdata_reg   <= '0;
         wmask_reg   <= '0;
      end else begin
         w_state_reg <= w_state_next;
         if (aw_hs) begin
            aw_full_reg <= 1'b1;
            aw_addr_reg <= s_awaddr[ADDR_W+1:2];
            aw_err_reg  <= aw_oor;
         end
         if (w_hs) begin
            w_full_reg <= 1'b1;
            wdata_reg  <= s_wdata;
            wmask_reg  <= s_wstrb;
         end
         if (w_state_reg == W_RESP && s_bready) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
         end
      end
   end

   assign sram_b_en    = (w_state_reg == W_ISSUE) && !aw_err_reg;
   assign sram_b_we    = sram_b_en;
   assign sram_b_addr  = aw_addr_reg;
   assign sram_b_wdata = wdata_reg;
   assign sram_b_wmask = wmask_reg;
   assign s_bvalid     = (w_state_reg == W_RESP);
   assign s_bresp      = aw_err_reg ? RESP_SLVERR : RESP_OKAY;

   // Read channel: the SRAM request is issued in the AR handshake cycle itself.
   assign s_arready   = (r_state_reg == R_IDLE);
   assign ar_hs       = s_arvalid && s_arready;
   assign sram_a_en   = ar_hs && !ar_oor;
   assign sram_a_re   = sram_a_en;
   assign sram_a_addr = s_araddr[ADDR_W+1:2];

   always_comb begin
      r_state_next = r_state_reg;
      case (r_state_reg)
         R_IDLE:  if (ar_hs) r_state_next = ar_oor ? R_RESP : R_WAIT;
         R_WAIT:  if (sram_a_rvalid) r_state_next = R_RESP;
         R_RESP:  if (s_rready) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_reg <= R_IDLE;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
      end else begin
         r_state_reg <= r_state_next;
         if (r_state_reg == R_IDLE && ar_hs && ar_oor) begin
            rdata_reg <= '0;
            rresp_reg <= RESP_SLVERR;
         end else if (r_state_reg == R_WAIT && sram_a_rvalid) begin
            rdata_reg <= sram_a_rdata;
            rresp_reg <= RESP_OKAY;
         end
      end
   end

   assign s_rvalid = (r_state_reg == R_RESP);
   assign s_rdata  = rdata_reg;
   assign s_rresp  = rresp_reg;

endmodule

// File: tb/tb_axil_sram_frontend.sv
// Randomized bench for axil_sram_frontend with a behavioural SRAM and a word-array reference model.
module tb_axil_sram_frontend;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [31:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;
   logic        sram_a_en, sram_a_re, sram_a_rvalid;
   logic [ADDR_W-1:0] sram_a_addr, sram_b_addr;
   logic [31:0] sram_a_rdata, sram_b_wdata;
   logic        sram_b_en, sram_b_we;
   logic [3:0]  sram_b_wmask;

   axil_sram_frontend dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .sram_a_en(sram_a_en), .sram_a_re(sram_a_re), .sram_a_addr(sram_a_addr),
      .sram_a_rdata(sram_a_rdata), .sram_a_rvalid(sram_a_rvalid),
      .sram_b_en(sram_b_en), .sram_b_we(sram_b_we), .sram_b_addr(sram_b_addr),
      .sram_b_wdata(sram_b_wdata), .sram_b_wmask(sram_b_wmask)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Behavioural SRAM macro: 2-cycle read pipeline, write-first, not reset (in-flight reads survive).
   logic [31:0]       sram_mem [DEPTH] = '{default: 32'h0};
   logic              p1_v = 1'b0, p2_v = 1'b0;
   logic [ADDR_W-1:0] p1_a = '0;
   logic [31:0]       p2_d = '0;
   always @(posedge clk) begin
      if (sram_b_en && sram_b_we)
         sram_mem[sram_b_addr] <= merge_bytes(sram_mem[sram_b_addr], sram_b_wdata, sram_b_wmask);
      p1_v <= sram_a_en && sram_a_re;
      p1_a <= sram_a_addr;
      p2_v <= p1_v;
      if (sram_b_en && sram_b_we && sram_b_addr == p1_a)
         p2_d <= merge_bytes(sram_mem[p1_a], sram_b_wdata, sram_b_wmask);
      else
         p2_d <= sram_mem[p1_a];
   end
   assign sram_a_rvalid = p2_v;
   assign sram_a_rdata  = p2_d;

   // Port activity monitor
   int                b_en_cnt = 0, b_en_cyc = -1, a_en_cnt = 0, a_en_cyc = -1;
   logic [ADDR_W-1:0] b_addr_seen = '0, a_addr_seen = '0;
   logic [31:0]       b_data_seen = '0;
   logic [3:0]        b_mask_seen = '0;
   always @(negedge clk) begin
      if (sram_b_en && sram_b_we) begin
         b_en_cnt    <= b_en_cnt + 1;
         b_en_cyc    <= cyc;
         b_addr_seen <= sram_b_addr;
         b_data_seen <= sram_b_wdata;
         b_mask_seen <= sram_b_wmask;
      end
      if (sram_a_en && sram_a_re) begin
         a_en_cnt    <= a_en_cnt + 1;
         a_en_cyc    <= cyc;
         a_addr_seen <= sram_a_addr;
      end
   end

   // Reference model: expected contents of every word
   logic [31:0] exp_mem [DEPTH] = '{default: 32'h0};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // All driver tasks start and end just after a rising edge.
   task automatic do_aw(input logic [31:0] addr, input int dly, output int hs_cyc);
      bit done = 1'b0;
      hs_cyc = -1;
      repeat (dly) begin @(posedge clk); #1; end
      s_awaddr = addr; s_awvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (s_awready) begin done = 1'b1; hs_cyc = cyc; end
         @(posedge clk); #1;
      end
      s_awvalid = 1'b0;
      check_eq("aw_handshake", 32'(done), 32'd1);
   endtask

   task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input int dly, output int hs_cyc);
      bit done = 1'b0;
      hs_cyc = -1;
      repeat (dly) begin @(posedge clk); #1; end
      s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (s_wready) begin done = 1'b1; hs_cyc = cyc; end
         @(posedge clk); #1;
      end
      s_wvalid = 1'b0;
      check_eq("w_handshake", 32'(done), 32'd1);
   endtask

   task automatic do_ar(input logic [31:0] addr, output int hs_cyc, output int waits);
      bit done = 1'b0;
      hs_cyc = -1; waits = -1;
      s_araddr = addr; s_arvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (s_arready) begin done = 1'b1; hs_cyc = cyc; waits = i; end
         @(posedge clk); #1;
      end
      s_arvalid = 1'b0;
      check_eq("ar_handshake", 32'(done), 32'd1);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit oor);
      int aw_c, w_c, t, first, b0;
      bit seen = 1'b0, hold_ok = 1'b1;
      logic [ADDR_W-1:0] word;
      word = addr[ADDR_W+1:2];
      b0 = b_en_cnt;
      fork
         do_aw(addr, aw_dly, aw_c);
         do_w(data, strb, w_dly, w_c);
      join
      t = (aw_c > w_c) ? aw_c : w_c;
      first = -1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (s_bvalid) begin seen = 1'b1; first = cyc; end
         else begin @(posedge clk); #1; end
      end
      check_eq("bvalid_latency", 32'(first - t), 32'd2);
      repeat (b_dly) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!s_bvalid || s_awready || s_wready) hold_ok = 1'b0;
      end
      check_eq("b_hold", 32'(hold_ok), 32'd1);
      @(posedge clk); #1;
      s_bready = 1'b1;
      @(negedge clk);
      check_eq("bvalid", 32'(s_bvalid), 32'd1);
      check_eq("bresp", 32'(s_bresp), oor ? 32'd2 : 32'd0);
      @(posedge clk); #1;
      s_bready = 1'b0;
      check_eq("b_en_count", 32'(b_en_cnt - b0), oor ? 32'd0 : 32'd1);
      if (!oor) begin
         check_eq("b_en_cycle", 32'(b_en_cyc - t), 32'd1);
         check_eq("b_addr", 32'(b_addr_seen), 32'(word));
         check_eq("b_wdata", b_data_seen, data);
         check_eq("b_wmask", 32'(b_mask_seen), 32'(strb));
         exp_mem[word] = merge_bytes(exp_mem[word], data, strb);
      end
      $display("WR addr=0x%08h data=0x%08h strb=0x%h aw_dly=%0d w_dly=%0d b_dly=%0d bresp=%0d",
               addr, data, strb, aw_dly, w_dly, b_dly, s_bresp);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_dly, input bit oor,
                           output logic [31:0] data, output int waits);
      int hs, first, a0;
      bit seen = 1'b0, hold_ok = 1'b1;
      logic [ADDR_W-1:0] word;
      word = addr[ADDR_W+1:2];
      a0 = a_en_cnt;
      do_ar(addr, hs, waits);
      first = -1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (s_rvalid) begin seen = 1'b1; first = cyc; end
         else begin @(posedge clk); #1; end
      end
      check_eq("rvalid_latency", 32'(first - hs), oor ? 32'd1 : 32'd3);
      data = s_rdata;
      check_eq("rdata", data, oor ? 32'h0 : exp_mem[word]);
      check_eq("rresp", 32'(s_rresp), oor ? 32'd2 : 32'd0);
      repeat (r_dly) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!s_rvalid || s_arready || s_rdata !== data) hold_ok = 1'b0;
      end
      check_eq("r_hold", 32'(hold_ok), 32'd1);
      @(posedge clk); #1;
      s_rready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      s_rready = 1'b0;
      check_eq("a_en_count", 32'(a_en_cnt - a0), oor ? 32'd0 : 32'd1);
      if (!oor) begin
         check_eq("a_en_cycle", 32'(a_en_cyc), 32'(hs));
         check_eq("a_addr", 32'(a_addr_seen), 32'(word));
      end
      $display("RD addr=0x%08h data=0x%08h r_dly=%0d rresp=%0d", addr, data, r_dly, s_rresp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] d, addr, data;
      int          w, a0, word, upper;
      bit          quiet_ok;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_bvalid", 32'(s_bvalid), 32'd0);
      check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
      check_eq("rst_rdata", s_rdata, 32'h0);
      check_eq("rst_resp", 32'({s_bresp, s_rresp}), 32'd0);
      check_eq("rst_sram_en", 32'({sram_a_en, sram_a_re, sram_b_en, sram_b_we}), 32'd0);
      check_eq("rst_b_regs", 32'(sram_b_addr) | sram_b_wdata | 32'(sram_b_wmask), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);

      axi_write(32'h8, 32'h11223344, 4'hF, 0, 0, 0, 1'b0);
      axi_write(32'h8, 32'hAABBCCDD, 4'h5, 0, 0, 0, 1'b0);
      axi_read(32'h8, 0, 1'b0, d, w);
      check_eq("partial_merge", d, 32'h11BB33DD);

      axi_write(32'h20, 32'hCAFEF00D, 4'hF, 3, 0, 5, 1'b0);
      axi_write(32'h20, 32'h0BADBEEF, 4'h0, 0, 1, 0, 1'b0);

      axi_read(32'h20, 4, 1'b0, d, w);
      axi_read(32'h10, 0, 1'b0, d, w);
      check_eq("ar_back_to_back", 32'(w), 32'd0);

      // Reset during R_WAIT: the pipelined SRAM data still arrives and must be dropped.
      a0 = a_en_cnt;
      s_araddr = 32'h10; s_arvalid = 1'b1;
      @(negedge clk);
      check_eq("rst_test_ar", 32'(s_arready), 32'd1);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      quiet_ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (s_rvalid || s_rdata !== 32'h0) quiet_ok = 1'b0;
         @(posedge clk); #1;
      end
      check_eq("stale_rvalid_ignored", 32'(quiet_ok), 32'd1);
      check_eq("rst_test_a_en", 32'(a_en_cnt - a0), 32'd1);
      axi_read(32'h10, 0, 1'b0, d, w);
      check_eq("read_after_reset", d, 32'hDEADBEEF);

      for (int i = 0; i < 40; i++) begin
         word  = int'($urandom_range(0, 15));
`ifdef AXIL_SRAM_RANGE_CHECK_EN
         upper = 0;
`else
         upper = int'($urandom_range(0, 3));
`endif
         addr = (32'(upper) << (ADDR_W + 2)) | (32'(word) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            data = $urandom;
            axi_write(addr, data, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
         end else begin
            axi_read(addr, int'($urandom_range(0, 3)), 1'b0, d, w);
         end
      end

`ifdef AXIL_SRAM_RANGE_CHECK_EN
      axi_read(32'(DEPTH * 4), 0, 1'b1, d, w);
      axi_write(32'(DEPTH * 4), 32'h55555555, 4'hF, 0, 0, 0, 1'b1);
      axi_read(32'h0, 0, 1'b0, d, w);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
